// File: rtl/axis_frame_bridge.sv
// axis_frame_bridge
//   Bridges an AXI-Stream source (DMA) to a compute core and back. One input
//   frame of IN_DATA_NUM beats is captured into a local input buffer, the core
//   is started, and once it reports done the OUT_DATA_NUM result beats it wrote
//   into the output buffer are streamed out with AXIS-compliant m_last.
//   Malformed input frames (s_last too early or missing) are dropped and flagged.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   slave stream (input frames)
//   m_data/m_valid/m_last/m_ready   master stream (result frames)
//   core_start      one-cycle pulse: input buffer holds a complete frame
//   core_done       core finished writing the output buffer (sampled in WAIT)
//   core_in_adr     core read address into the input buffer
//   core_in_data    input buffer word at core_in_adr (combinational)
//   core_out_adr/core_out_data/core_out_wr   core write port into output buffer
//   err_frame       one-cycle pulse on a framing error
//   frame_cnt       completed output frames (wraps)
//   err_cnt         framing errors (saturates)
module axis_frame_bridge #(
    parameter int DATA_WIDTH   = 32,
    parameter int IN_DATA_NUM  = 8,
    parameter int OUT_DATA_NUM = 4,
    parameter int CNT_WIDTH    = 16,
    localparam int IA = (IN_DATA_NUM  > 1) ? $clog2(IN_DATA_NUM)  : 1,
    localparam int OA = (OUT_DATA_NUM > 1) ? $clog2(OUT_DATA_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [IA-1:0]         core_in_adr,
    output logic [DATA_WIDTH-1:0] core_in_data,
    input  logic [OA-1:0]         core_out_adr,
    input  logic [DATA_WIDTH-1:0] core_out_data,
    input  logic                  core_out_wr,
    output logic                  err_frame,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [IA-1:0]        IN_LAST  = IA'(IN_DATA_NUM - 1);
    localparam logic [OA-1:0]        OUT_LAST = OA'(OUT_DATA_NUM - 1);
    localparam logic [IA-1:0]        IN_ONE   = IA'(1);
    localparam logic [OA-1:0]        OUT_ONE  = OA'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLAVE,
        ST_DRAIN,
        ST_START,
        ST_WAIT,
        ST_MASTER
    } state_t;

    state_t                 state_reg;
    logic                   s_ready_reg;
    logic                   m_valid_reg;
    logic                   m_last_reg;
    logic                   core_start_reg;
    logic                   err_frame_reg;
    logic [IA-1:0]          in_cnt_reg;
    logic [OA-1:0]          out_cnt_reg;
    logic [CNT_WIDTH-1:0]   frame_cnt_reg;
    logic [CNT_WIDTH-1:0]   err_cnt_reg;

    logic [DATA_WIDTH-1:0]  in_buf  [IN_DATA_NUM];
    logic [DATA_WIDTH-1:0]  out_buf [OUT_DATA_NUM];

    logic s_accept;
    logic m_accept;

    // s_ready is only ever high in SLAVE/DRAIN and m_valid only in MASTER,
    // so these handshakes already imply the owning state.
    assign s_accept = s_valid & s_ready_reg;
    assign m_accept = m_valid_reg & m_ready;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            s_ready_reg    <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
            core_start_reg <= 1'b0;
            err_frame_reg  <= 1'b0;
            in_cnt_reg     <= '0;
            out_cnt_reg    <= '0;
            frame_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            // Pulse outputs default low; set only on the cycle they fire.
            core_start_reg <= 1'b0;
            err_frame_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    in_cnt_reg  <= '0;
                    out_cnt_reg <= '0;
                    s_ready_reg <= 1'b1;
                    state_reg   <= ST_SLAVE;
                end
                ST_SLAVE: begin
                    if (s_accept) begin
                        if (s_last) begin
                            in_cnt_reg <= '0;
                            if (in_cnt_reg == IN_LAST) begin
                                // core_start is raised here so it is high for
                                // exactly the single START cycle.
                                core_start_reg <= 1'b1;
                                s_ready_reg    <= 1'b0;
                                state_reg      <= ST_START;
                            end else begin
                                // Short frame: drop it and restart capture.
                                err_frame_reg <= 1'b1;
                                err_cnt_reg   <= sat_inc(err_cnt_reg);
                            end
                        end else if (in_cnt_reg == IN_LAST) begin
                            // Long frame: discard the remainder up to s_last.
                            err_frame_reg <= 1'b1;
                            err_cnt_reg   <= sat_inc(err_cnt_reg);
                            in_cnt_reg    <= '0;
                            state_reg     <= ST_DRAIN;
                        end else begin
                            in_cnt_reg <= in_cnt_reg + IN_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_accept && s_last) begin
                        in_cnt_reg <= '0;
                        state_reg  <= ST_SLAVE;
                    end
                end
                ST_START: begin
                    out_cnt_reg <= '0;
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= (OUT_LAST == '0);
                        state_reg   <= ST_MASTER;
                    end
                end
                ST_MASTER: begin
                    if (m_accept) begin
                        if (out_cnt_reg == OUT_LAST) begin
                            m_valid_reg   <= 1'b0;
                            m_last_reg    <= 1'b0;
                            frame_cnt_reg <= frame_cnt_reg + CNT_ONE;
                            in_cnt_reg    <= '0;
                            s_ready_reg   <= 1'b1;
                            state_reg     <= ST_SLAVE;
                        end else begin
                            out_cnt_reg <= out_cnt_reg + OUT_ONE;
                            m_last_reg  <= ((out_cnt_reg + OUT_ONE) == OUT_LAST);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffers are never cleared; they only change on an accepted input beat
    // (input side) or on a core write while the core owns them (output side).
    always_ff @(posedge clk) begin
        if (!rst && state_reg == ST_SLAVE && s_accept) begin
            in_buf[in_cnt_reg] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_reg == ST_WAIT && core_out_wr) begin
            out_buf[core_out_adr] <= core_out_data;
        end
    end

    // The output buffer is frozen outside WAIT, so reading it through out_cnt
    // keeps m_data stable across a stall without an extra holding register.
    assign m_data       = m_valid_reg ? out_buf[out_cnt_reg] : '0;
    assign core_in_data = in_buf[core_in_adr];

    assign s_ready    = s_ready_reg;
    assign m_valid    = m_valid_reg;
    assign m_last     = m_last_reg;
    assign core_start = core_start_reg;
    assign err_frame  = err_frame_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_axis_frame_bridge.sv
// tb_axis_frame_bridge
//   Drives input frames into axis_frame_bridge, emulates the compute core
//   (out[j] = in[2j] + in[2j+1]) and checks the streamed results, framing error
//   handling, counters, stall behaviour and reset against a frame-level model.
module tb_axis_frame_bridge;

    localparam int DW  = 32;
    localparam int IN  = 8;
    localparam int OUT = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          core_start;
    logic          core_done;
    logic [2:0]    core_in_adr;
    logic [DW-1:0] core_in_data;
    logic [1:0]    core_out_adr;
    logic [DW-1:0] core_out_data;
    logic          core_out_wr;
    logic          err_frame;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    axis_frame_bridge #(
        .DATA_WIDTH(DW), .IN_DATA_NUM(IN), .OUT_DATA_NUM(OUT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .core_start(core_start), .core_done(core_done),
        .core_in_adr(core_in_adr), .core_in_data(core_in_data),
        .core_out_adr(core_out_adr), .core_out_data(core_out_data),
        .core_out_wr(core_out_wr),
        .err_frame(err_frame), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int len;
        int rmode;      // 0: m_ready high, 1: toggling 1010.., 2: random
        int delay;      // core idle cycles before core_done
        bit early;      // core also pulses core_done during START
        bit skip;       // core writes nothing to the output buffer
        bit exp_err;
        bit exp_start;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t rx[$];
    int    start_seen = 0;
    int    err_seen   = 0;

    int         core_delay = 3;
    bit         core_early = 1'b0;
    bit         core_skip  = 1'b0;
    int         junk_req   = 0;
    logic [1:0] junk_adr   = 2'd0;

    logic [DW-1:0] mdl_outbuf [OUT];
    int exp_frames = 0;
    int exp_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Output monitor: samples just after the falling edge, records accepted
    // beats and checks that a stalled beat holds still.
    initial begin : monitor
        bit            prev_stall = 1'b0;
        bit            prev_start = 1'b0;
        bit            prev_err   = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        beat_t         b;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_stall = 1'b0;
                prev_start = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", m_data, prev_data);
                    check("hold_last", 32'(m_last), 32'(prev_last));
                end
                if (m_valid && m_ready) begin
                    b.data = m_data;
                    b.last = m_last;
                    rx.push_back(b);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                if (core_start) begin
                    start_seen++;
                    check("start_width", 32'(prev_start), 32'd0);
                end
                if (err_frame) begin
                    err_seen++;
                    check("err_width", 32'(prev_err), 32'd0);
                end
                prev_start = core_start;
                prev_err   = err_frame;
            end
        end
    end

    // Compute-core emulation.
    initial begin : core_model
        int            junk_done = 0;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        core_done     = 1'b0;
        core_out_wr   = 1'b0;
        core_in_adr   = '0;
        core_out_adr  = '0;
        core_out_data = '0;
        forever begin
            @(negedge clk);
            if (junk_req != junk_done) begin
                junk_done++;
                core_out_adr  = junk_adr;
                core_out_data = 32'h0000_DEAD;
                core_out_wr   = 1'b1;
                @(negedge clk);
                core_out_wr = 1'b0;
            end else if (core_start && !rst) begin
                if (core_early) core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                if (!core_skip) begin
                    for (int j = 0; j < OUT; j++) begin
                        core_in_adr = 3'(2 * j);
                        #1 a = core_in_data;
                        core_in_adr = 3'(2 * j + 1);
                        #1 b = core_in_data;
                        core_out_adr  = 2'(j);
                        core_out_data = a + b;
                        core_out_wr   = 1'b1;
                        @(negedge clk);
                    end
                end
                core_out_wr = 1'b0;
                repeat (core_delay) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("s_ready_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input int len, input int rmode, input int delay,
                             input bit early, input bit skip,
                             input bit exp_err, input bit exp_start, input string tag);
        logic [DW-1:0] d    [16];
        logic [DW-1:0] expv [OUT];
        int st0 = start_seen;
        int er0 = err_seen;
        int t;
        bit tog;
        core_delay = delay;
        core_early = early;
        core_skip  = skip;
        rx.delete();
        for (int i = 0; i < len; i++) begin
            d[i] = $urandom;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_beat(d[i], (i == len - 1));
        end
        if (len == IN) begin
            for (int j = 0; j < OUT; j++)
                expv[j] = skip ? mdl_outbuf[j] : d[2 * j] + d[2 * j + 1];
            t   = 0;
            tog = 1'b1;
            while (rx.size() < OUT && t < 400) begin
                case (rmode)
                    0:       m_ready = 1'b1;
                    1:       begin m_ready = tog; tog = !tog; end
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                @(negedge clk);
                t++;
            end
            m_ready = 1'b0;
            check({tag, "_nbeats"}, 32'(rx.size()), 32'(OUT));
            for (int j = 0; j < OUT && j < rx.size(); j++) begin
                check({tag, "_data"}, rx[j].data, expv[j]);
                check({tag, "_last"}, 32'(rx[j].last), 32'(j == OUT - 1));
            end
            for (int j = 0; j < OUT; j++) mdl_outbuf[j] = expv[j];
            exp_frames++;
        end else begin
            exp_errs++;
            repeat (2) @(negedge clk);
        end
        check({tag, "_err_pulses"}, 32'(err_seen - er0), 32'(exp_err));
        check({tag, "_start_pulses"}, 32'(start_seen - st0), 32'(exp_start));
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[CW-1:0]));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs[CW-1:0]));
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        $display("frame %s len=%0d rmode=%0d delay=%0d early=%0d skip=%0d frame_cnt=%0d err_cnt=%0d",
                 tag, len, rmode, delay, early, skip, frame_cnt, err_cnt);
    endtask

    initial begin : main
        vec_t          tbl [9];
        logic [DW-1:0] d    [IN];
        logic [DW-1:0] expv [OUT];
        int            t;
        int            len;
        int            kind;

        tbl[0] = '{8,  0, 3, 1'b0, 1'b0, 1'b0, 1'b1};  // plain good frame
        tbl[1] = '{5,  0, 3, 1'b0, 1'b0, 1'b1, 1'b0};  // short: last on beat 5
        tbl[2] = '{8,  1, 2, 1'b0, 1'b0, 1'b0, 1'b1};  // good after error, toggled ready
        tbl[3] = '{10, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};  // long: last on beat 10
        tbl[4] = '{1,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0};  // single-beat short frame
        tbl[5] = '{8,  2, 0, 1'b1, 1'b0, 1'b0, 1'b1};  // core_done during START ignored
        tbl[6] = '{9,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0};  // one beat too many
        tbl[7] = '{7,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0};  // one beat too few
        tbl[8] = '{8,  1, 5, 1'b0, 1'b0, 1'b0, 1'b1};  // long core latency

        rst     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_err_frame", 32'(err_frame), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_to_slave_s_ready", 32'(s_ready), 32'd1);

        for (int v = 0; v < 9; v++)
            run_frame(tbl[v].len, tbl[v].rmode, tbl[v].delay, tbl[v].early,
                      tbl[v].skip, tbl[v].exp_err, tbl[v].exp_start, $sformatf("tbl%0d", v));

        // Core writes while the bridge is in SLAVE must not reach the output
        // buffer: the core then writes nothing, so the previous results reappear.
        junk_adr = 2'($urandom_range(0, OUT - 1));
        junk_req++;
        repeat (3) @(negedge clk);
        run_frame(IN, 0, 2, 1'b0, 1'b1, 1'b0, 1'b1, "junk_wr");

        // Reset in MASTER after two accepted output beats.
        core_delay = 2;
        core_early = 1'b0;
        core_skip  = 1'b0;
        rx.delete();
        for (int i = 0; i < IN; i++) begin
            d[i] = $urandom;
            send_beat(d[i], (i == IN - 1));
        end
        for (int j = 0; j < OUT; j++) begin
            expv[j]       = d[2 * j] + d[2 * j + 1];
            mdl_outbuf[j] = expv[j];
        end
        t = 0;
        while (!m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rstm_reach_master", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("rstm_s_ready", 32'(s_ready), 32'd0);
        check("rstm_m_valid", 32'(m_valid), 32'd0);
        check("rstm_m_last", 32'(m_last), 32'd0);
        check("rstm_m_data", m_data, 32'd0);
        check("rstm_core_start", 32'(core_start), 32'd0);
        check("rstm_err_frame", 32'(err_frame), 32'd0);
        check("rstm_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rstm_err_cnt", 32'(err_cnt), 32'd0);
        check("rstm_beats_before", 32'(rx.size()), 32'd2);
        if (rx.size() >= 2) begin
            check("rstm_beat0", rx[0].data, expv[0]);
            check("rstm_beat1", rx[1].data, expv[1]);
        end
        $display("reset in MASTER after %0d beats: frame_cnt=%0d err_cnt=%0d",
                 rx.size(), frame_cnt, err_cnt);
        rst        = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        @(negedge clk);
        check("rstm_resume_s_ready", 32'(s_ready), 32'd1);
        run_frame(IN, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

        for (int r = 0; r < 24; r++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)      len = IN;
            else if (kind == 1) len = int'($urandom_range(1, IN - 1));
            else                len = int'($urandom_range(IN + 1, IN + 4));
            run_frame(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      (len != IN), (len == IN), $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
